// File: rtl/jtdd_mcu_com.sv
// jtdd_mcu_com
// Com block shared by the main 6809 and the HD63701 sub-MCU.
// - Holds a 2^AW x 8 single-port com RAM. The MCU owns it unless the
//   FSM is in HALTED, where main owns it.
// - Halt/bus-available handshake: the main CPU raises mcu_halt. This block
//   freezes the MCU through mcu_stall, then grants the RAM with mcu_ban.
// - NMI latch from main to the MCU, and a stretched IRQ from the MCU to main.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   main_cs/we/addr/din/dout     main CPU side of the com RAM
//   mcu_halt, mcu_ban            halt request in, bus available out
//   nmi_set -> mcu_nmi           NMI to MCU, cleared by mcu_nmi_clr
//   mcu_irq_req -> mcu_irqmain   IRQ_LEN-cycle IRQ pulse to main
//   mcu_cen/addr/wr/dout/din     MCU side of the com RAM
//   mcu_ramsel, mcu_stall        address hit, MCU core freeze
module jtdd_mcu_com #(
  parameter int          AW       = 9,
  parameter int          HALT_DLY = 2,
  parameter int          IRQ_LEN  = 8,
  parameter logic [15:0] MCU_BASE = 16'h8000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mcu_cen,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_din,
  output logic [7:0]    main_dout,
  input  logic          mcu_halt,
  input  logic          nmi_set,
  output logic          mcu_ban,
  output logic          mcu_irqmain,
  input  logic [15:0]   mcu_addr,
  input  logic          mcu_wr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  output logic          mcu_ramsel,
  output logic          mcu_stall,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_clr,
  input  logic          mcu_irq_req
);

  localparam int DW = (HALT_DLY > 0) ? $clog2(HALT_DLY+1) : 1;
  localparam int IW = (IRQ_LEN  > 0) ? $clog2(IRQ_LEN+1)  : 1;

  typedef enum logic [1:0] {RUN, HREQ, HWAIT, HALTED} st_t;

  st_t           st, st_nx;
  logic [DW-1:0] dly, dly_nx;
  logic          stall_nx, ban_nx;
  logic [IW-1:0] irq_cnt;

  logic [7:0]    mem [0:(2**AW)-1];
  logic          owner_main;
  logic          mcu_we;
  logic [AW-1:0] ram_a;
  logic          ram_we;
  logic [7:0]    ram_wd;

  assign mcu_ramsel = mcu_addr[15:AW] == MCU_BASE[15:AW];
  // A stalled core still drives its bus. Its strobes must not reach the RAM.
  assign mcu_we     = mcu_cen & mcu_wr & mcu_ramsel & ~mcu_stall;
  assign owner_main = st == HALTED;

  // Arbitration FSM
  always_comb begin
    st_nx    = st;
    dly_nx   = dly;
    stall_nx = mcu_stall;
    ban_nx   = mcu_ban;
    case (st)
      RUN: begin
        // A stall left over from a grant or an abort drops on the next cen.
        if (mcu_stall && mcu_cen) stall_nx = 1'b0;
        // Do not take the RAM away in the middle of an MCU write.
        if (mcu_halt && !mcu_we)  st_nx    = HREQ;
      end
      HREQ: begin
        if (!mcu_halt) st_nx = RUN;
        else if (mcu_cen) begin
          stall_nx = 1'b1;
          dly_nx   = DW'(HALT_DLY);
          st_nx    = HWAIT;
        end
      end
      HWAIT: begin
        if (!mcu_halt) st_nx = RUN;
        else if (mcu_cen) begin
          // The count reaches zero on this tick, so grant on this tick.
          if (dly <= DW'(1)) begin
            dly_nx = '0;
            ban_nx = 1'b1;
            st_nx  = HALTED;
          end else begin
            dly_nx = dly - DW'(1);
          end
        end
      end
      HALTED: begin
        if (!mcu_halt) begin
          ban_nx = 1'b0;
          st_nx  = RUN;
        end
      end
      default: st_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= RUN;
      dly       <= '0;
      mcu_stall <= 1'b0;
      mcu_ban   <= 1'b0;
    end else begin
      st        <= st_nx;
      dly       <= dly_nx;
      mcu_stall <= stall_nx;
      mcu_ban   <= ban_nx;
    end
  end

  // Single-port RAM. Address, write enable and data come from the owner.
  always_comb begin
    ram_a  = owner_main ? main_addr : mcu_addr[AW-1:0];
    ram_we = owner_main ? (main_we & main_cs) : mcu_we;
    ram_wd = owner_main ? main_din : mcu_dout;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_wd;
  end

  // Registered read ports. Main sees 8'hff while locked out. The MCU port
  // keeps its last word while main owns the RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_dout <= 8'hff;
      mcu_din   <= 8'h00;
    end else begin
      main_dout <= owner_main ? mem[ram_a] : 8'hff;
      if (!owner_main) mcu_din <= mem[ram_a];
    end
  end

  // NMI latch. When set and clear arrive together, set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            mcu_nmi <= 1'b0;
    else if (nmi_set)     mcu_nmi <= 1'b1;
    else if (mcu_nmi_clr) mcu_nmi <= 1'b0;
  end

  // IRQ stretcher. A new request reloads the count, which extends the
  // current pulse instead of making a new edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                irq_cnt <= '0;
    else if (mcu_irq_req)     irq_cnt <= IW'(IRQ_LEN);
    else if (irq_cnt != '0)   irq_cnt <= irq_cnt - IW'(1);
  end

  assign mcu_irqmain = irq_cnt != '0;

endmodule

// File: tb/tb_jtdd_mcu_com.sv
// Bench for jtdd_mcu_com. RAM accesses come from vector tables. Read
// expectations go into a scoreboard queue when the read is issued. They
// are popped and compared when the registered data appears.
module tb_jtdd_mcu_com;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mcu_cen, main_cs, main_we, mcu_halt, nmi_set;
  logic [AW-1:0] main_addr;
  logic [7:0]    main_din, main_dout;
  logic          mcu_ban, mcu_irqmain;
  logic [15:0]   mcu_addr;
  logic          mcu_wr;
  logic [7:0]    mcu_dout, mcu_din;
  logic          mcu_ramsel, mcu_stall, mcu_nmi, mcu_nmi_clr, mcu_irq_req;

  jtdd_mcu_com #(.AW(AW), .HALT_DLY(2), .IRQ_LEN(8), .MCU_BASE(16'h8000)) dut (
    .clk(clk), .rstn(rstn), .mcu_cen(mcu_cen), .main_cs(main_cs),
    .main_we(main_we), .main_addr(main_addr), .main_din(main_din),
    .main_dout(main_dout), .mcu_halt(mcu_halt), .nmi_set(nmi_set),
    .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain), .mcu_addr(mcu_addr),
    .mcu_wr(mcu_wr), .mcu_dout(mcu_dout), .mcu_din(mcu_din),
    .mcu_ramsel(mcu_ramsel), .mcu_stall(mcu_stall), .mcu_nmi(mcu_nmi),
    .mcu_nmi_clr(mcu_nmi_clr), .mcu_irq_req(mcu_irq_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mcu;   // 1: MCU port, 0: main port
    bit          wr;    // 1: write data, 0: read and expect data
    logic [15:0] addr;
    logic [7:0]  data;
    string       name;
  } vec_t;

  typedef struct {
    bit         mcu;
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t th[7];
  vec_t tr[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit cen);
    mcu_cen = cen;
    @(posedge clk);
    #1;
    mcu_cen = 1'b0;
  endtask

  // Three idle clocks, then one mcu_cen clock. mcu_cen comes every 4 clk.
  task automatic cen_tick();
    cyc(0); cyc(0); cyc(0); cyc(1);
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    if (!v.wr) sb_q.push_back('{mcu: v.mcu, exp: v.data, name: v.name});
    if (v.mcu) begin
      mcu_addr = v.addr; mcu_wr = v.wr; mcu_dout = v.data;
      cyc(v.wr);
      mcu_wr = 1'b0;
    end else begin
      main_cs = 1'b1; main_we = v.wr; main_addr = v.addr[AW-1:0]; main_din = v.data;
      cyc(0);
      main_we = 1'b0; main_cs = 1'b0;
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(e.name, e.mcu ? mcu_din : main_dout, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Accesses while HALTED: main owns the RAM, and the MCU write is dropped.
    th[0] = '{mcu:0, wr:1, addr:16'h01f0, data:8'h5a, name:"w"};
    th[1] = '{mcu:0, wr:1, addr:16'h0000, data:8'h11, name:"w"};
    th[2] = '{mcu:0, wr:1, addr:16'h01ff, data:8'h22, name:"w"};
    th[3] = '{mcu:1, wr:1, addr:16'h81f0, data:8'h99, name:"w"};
    th[4] = '{mcu:0, wr:0, addr:16'h01f0, data:8'h5a, name:"main_rd_1f0"};
    th[5] = '{mcu:0, wr:0, addr:16'h0000, data:8'h11, name:"main_rd_000"};
    th[6] = '{mcu:0, wr:0, addr:16'h01ff, data:8'h22, name:"main_rd_1ff"};
    // Accesses in RUN: the MCU owns the RAM, and the main write is dropped.
    tr[0] = '{mcu:1, wr:0, addr:16'h81f0, data:8'h5a, name:"mcu_rd_81f0"};
    tr[1] = '{mcu:1, wr:0, addr:16'h8000, data:8'h11, name:"mcu_rd_8000"};
    tr[2] = '{mcu:1, wr:0, addr:16'h81ff, data:8'h22, name:"mcu_rd_81ff"};
    tr[3] = '{mcu:1, wr:0, addr:16'h83f0, data:8'h5a, name:"mcu_rd_wrap"};
    tr[4] = '{mcu:1, wr:1, addr:16'h8010, data:8'h33, name:"w"};
    tr[5] = '{mcu:0, wr:1, addr:16'h0010, data:8'haa, name:"w"};
    tr[6] = '{mcu:1, wr:0, addr:16'h8010, data:8'h33, name:"mcu_rd_dropped"};
    tr[7] = '{mcu:0, wr:0, addr:16'h0010, data:8'hff, name:"main_rd_run"};

    rstn = 1'b0; mcu_cen = 0; main_cs = 0; main_we = 0; main_addr = '0; main_din = 0;
    mcu_halt = 0; nmi_set = 0; mcu_addr = 16'h0000; mcu_wr = 0; mcu_dout = 0;
    mcu_nmi_clr = 0; mcu_irq_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_main_dout", main_dout, 8'hff);
    chk("rst_mcu_din", mcu_din, 8'h00);
    chk("rst_ban", {7'd0, mcu_ban}, 8'd0);
    chk("rst_stall", {7'd0, mcu_stall}, 8'd0);
    chk("rst_nmi", {7'd0, mcu_nmi}, 8'd0);
    chk("rst_irq", {7'd0, mcu_irqmain}, 8'd0);
    rstn = 1'b1;
    cyc(0);

    // Address decode
    mcu_addr = 16'h81f0; #1; chk("ramsel_81f0", {7'd0, mcu_ramsel}, 8'd1);
    mcu_addr = 16'h8200; #1; chk("ramsel_8200", {7'd0, mcu_ramsel}, 8'd0);
    mcu_addr = 16'h7fff; #1; chk("ramsel_7fff", {7'd0, mcu_ramsel}, 8'd0);
    mcu_addr = 16'h0000;

    // Halt handshake
    mcu_halt = 1'b1;
    cyc(0);
    chk("hreq_stall", {7'd0, mcu_stall}, 8'd0);
    cen_tick();
    chk("stall_on", {7'd0, mcu_stall}, 8'd1);
    chk("ban_wait1", {7'd0, mcu_ban}, 8'd0);
    cen_tick();
    chk("ban_wait2", {7'd0, mcu_ban}, 8'd0);
    cen_tick();
    chk("ban_on", {7'd0, mcu_ban}, 8'd1);
    for (int i = 0; i < 7; i++) run_vec(th[i]);

    // Release: ban drops on the next clk, and stall drops on the next cen.
    mcu_halt = 1'b0;
    cyc(0);
    chk("ban_off", {7'd0, mcu_ban}, 8'd0);
    chk("stall_hold", {7'd0, mcu_stall}, 8'd1);
    run_vec('{mcu:0, wr:0, addr:16'h01f0, data:8'hff, name:"main_rd_locked"});
    cen_tick();
    chk("stall_off", {7'd0, mcu_stall}, 8'd0);
    for (int i = 0; i < 8; i++) run_vec(tr[i]);

    // NMI latch
    nmi_set = 1; mcu_nmi_clr = 1; cyc(0); nmi_set = 0; mcu_nmi_clr = 0;
    chk("nmi_set_wins", {7'd0, mcu_nmi}, 8'd1);
    cyc(0);
    chk("nmi_hold", {7'd0, mcu_nmi}, 8'd1);
    mcu_nmi_clr = 1; cyc(0); mcu_nmi_clr = 0;
    chk("nmi_clr", {7'd0, mcu_nmi}, 8'd0);

    // IRQ stretch: requests at t=0 and t=5 give one pulse from t=1 to t=13.
    for (int t = 0; t < 15; t++) begin
      mcu_irq_req = (t == 0 || t == 5);
      cyc(0);
      chk($sformatf("irq_t%0d", t+1), {7'd0, mcu_irqmain}, {7'd0, (t+1 <= 13)});
    end
    mcu_irq_req = 0;

    // Reset during HWAIT clears everything at once, without waiting for a clock edge.
    mcu_halt = 1'b1;
    cyc(0);
    cen_tick();
    chk("hwait_stall", {7'd0, mcu_stall}, 8'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_stall", {7'd0, mcu_stall}, 8'd0);
    chk("arst_ban", {7'd0, mcu_ban}, 8'd0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    cen_tick();
    chk("rehalt_stall", {7'd0, mcu_stall}, 8'd1);
    cen_tick();
    cen_tick();
    chk("rehalt_ban", {7'd0, mcu_ban}, 8'd1);
    run_vec('{mcu:0, wr:0, addr:16'h01f0, data:8'h5a, name:"main_rd_rehalt"});
    mcu_halt = 1'b0;
    cyc(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtdd_mcu_com.md
# jtdd_mcu_com

Shared communication block between the main 6809 and the HD63701 sub-MCU. It holds the 512-byte com RAM decoded by the main CPU at 0x2000–0x27FF, and grants it to either side through a halt/bus-available handshake. It also carries the NMI request from main to MCU and a stretched IRQ request from MCU to main. Its outputs feed the main CPU's `mcu_ram`, `mcu_ban` and `mcu_irqmain` inputs directly.

## Interface
Parameters:
- `AW`, 9: com RAM address width (2^AW bytes).
- `HALT_DLY`, 2: `mcu_cen` ticks between halt acceptance and bus grant.
- `IRQ_LEN`, 8: `clk` cycles `mcu_irqmain` stays high per request.
- `MCU_BASE`, 16'h8000: MCU-side base address of the com RAM; must be aligned to 2^AW.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `mcu_cen` in 1: MCU clock enable.
- `main_cs` in 1: main com RAM select (level).
- `main_we` in 1: main write strobe; one `clk` wide, qualified by the main `cpu_cen`.
- `main_addr` in AW: main address (`cpu_AB[AW-1:0]`).
- `main_din` in 8: main write data.
- `main_dout` out 8: read data to main (`mcu_ram`).
- `mcu_halt` in 1: halt request from the main misc register.
- `nmi_set` in 1: NMI set pulse from main.
- `mcu_ban` out 1: bus available to main.
- `mcu_irqmain` out 1: IRQ request to main.
- `mcu_addr` in 16: MCU address bus.
- `mcu_wr` in 1: MCU write strobe, valid on `mcu_cen`.
- `mcu_dout` in 8: MCU write data.
- `mcu_din` out 8: com RAM read data to MCU.
- `mcu_ramsel` out 1: MCU address hits the com RAM (combinational).
- `mcu_stall` out 1: freezes the MCU core (gates its `cen`).
- `mcu_nmi` out 1: NMI level to MCU.
- `mcu_nmi_clr` in 1: MCU NMI-acknowledge pulse.
- `mcu_irq_req` in 1: MCU request to interrupt main (pulse).

## Operation
- Storage is a single-port 2^AW x 8 RAM with one owner per cycle. The MCU owns it in every state except HALTED, where main owns it.
- `mcu_ramsel = mcu_addr[15:AW] == MCU_BASE[15:AW]`.
- Arbitration FSM states: RUN, HREQ, HWAIT, HALTED.
  - RUN: if `mcu_halt` is high and there is no MCU RAM write in the same cycle, go to HREQ.
  - HREQ: on the next `mcu_cen`, assert `mcu_stall` and load the delay counter with HALT_DLY. Go to HWAIT.
  - HWAIT: decrement the counter on each `mcu_cen`. At zero, go to HALTED and set `mcu_ban` to 1.
  - HALTED: when `mcu_halt` falls, `mcu_ban` falls in the same cycle (registered on that edge). `mcu_stall` releases on the next `mcu_cen`, and the FSM returns to RUN.
  - If `mcu_halt` drops during HREQ or HWAIT: abort to RUN, release `mcu_stall` on the next `mcu_cen`, and never assert `mcu_ban`.
- Main access:
  - Owner main: writes are committed on `main_we & main_cs`. Reads return the RAM word.
  - Owner not main: writes are dropped, and `main_dout` returns 8'hff.
- MCU access:
  - Owner MCU: writes are committed on `mcu_cen & mcu_wr & mcu_ramsel`.
  - While `mcu_stall` is high, MCU strobes are ignored.
  - `mcu_din` holds its last value when not owner.
- NMI latch:
  - `nmi_set` sets `mcu_nmi`; `mcu_nmi_clr` clears it.
  - If both arrive in the same cycle, set wins.
- IRQ stretcher:
  - `mcu_irq_req` loads a counter with IRQ_LEN, and `mcu_irqmain` is high while the counter is nonzero.
  - A new request during the high period reloads the counter; it does not produce a second edge.

## Timing
- Reset values: `main_dout` = 8'hff, `mcu_din` = 8'h00, `mcu_ban` = 0, `mcu_stall` = 0, `mcu_nmi` = 0, `mcu_irqmain` = 0, FSM in RUN, all counters 0. RAM contents are not reset.
- Reset asserted mid-halt: everything returns to RUN immediately (asynchronous), and `mcu_stall` drops without waiting for `mcu_cen`.
- Read latency: 1 `clk` for both sides, with registered `main_dout` and `mcu_din`. The main CPU's `cpu_cen` is at least 4 `clk` apart, so data is stable before sampling.
- Grant latency from `mcu_halt` rising: 1 `clk` (RUN→HREQ), then 1 `mcu_cen`, then HALT_DLY `mcu_cen` ticks.
- `mcu_nmi` rises 1 `clk` after `nmi_set`.
- `mcu_irqmain` rises 1 `clk` after `mcu_irq_req` and stays high exactly IRQ_LEN cycles.
- Address wrap: `main_addr` and the low bits of `mcu_addr` are used modulo 2^AW.

## Test plan
- Reset, then `mcu_halt` = 1 with `mcu_cen` every 4 `clk` → `mcu_stall` at the first `mcu_cen`, `mcu_ban` = 1 two `mcu_cen` later. Main write 8'h5a to 0x1f0, then read back → `main_dout` = 8'h5a.
- `mcu_halt` = 0 while HALTED → `mcu_ban` = 0 on the next clk. MCU reads 0x81f0 → `mcu_din` = 8'h5a one clk later. Main read now → 8'hff.
- Main write to 0x010 while in RUN → dropped: the MCU reads the old value and the RAM is unchanged.
- `nmi_set` and `mcu_nmi_clr` in the same cycle → `mcu_nmi` = 1. `mcu_nmi_clr` alone afterwards → `mcu_nmi` = 0.
- `mcu_irq_req` at t=0 and t=5 → `mcu_irqmain` high from t=1 to t=13 as a single pulse.
- `rstn` low during HWAIT → `mcu_stall` = 0 and `mcu_ban` = 0 immediately. After release the FSM is in RUN and a new halt completes normally.
